// File: rtl/bisr_weight_alloc_driver_pkg.sv
// rtl/bisr_weight_alloc_driver_pkg.sv - state encoding and fail counter helpers for the allocation driver
package bisr_weight_alloc_driver_pkg;

  localparam logic [3:0] ST_IDLE_ENC   = 4'd0;
  localparam logic [3:0] ST_FILL_ENC   = 4'd1;
  localparam logic [3:0] ST_START_ENC  = 4'd2;
  localparam logic [3:0] ST_STREAM_ENC = 4'd3;
  localparam logic [3:0] ST_SETTLE_ENC = 4'd4;
  localparam logic [3:0] ST_CHECK_ENC  = 4'd5;
  localparam logic [3:0] ST_READY_ENC  = 4'd6;
  localparam logic [3:0] ST_SWEEP_ENC  = 4'd7;
  localparam logic [3:0] ST_FAIL_ENC   = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_FILL   = ST_FILL_ENC,
    ST_START  = ST_START_ENC,
    ST_STREAM = ST_STREAM_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_CHECK  = ST_CHECK_ENC,
    ST_READY  = ST_READY_ENC,
    ST_SWEEP  = ST_SWEEP_ENC,
    ST_FAIL   = ST_FAIL_ENC
  } state_e;

  localparam int FAIL_COUNT_WIDTH = 8;

  function automatic logic [FAIL_COUNT_WIDTH-1:0] sat_inc(input logic [FAIL_COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bisr_row_buffer.sv
// rtl/bisr_row_buffer.sv - one-layer weight row register file, sync write, async read
module bisr_row_buffer #(
  parameter int DEPTH      = 8,
  parameter int ROW_WIDTH  = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ROW_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ROW_WIDTH-1:0]  rd_data
);

  logic [ROW_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bisr_weight_alloc_driver.sv
// rtl/bisr_weight_alloc_driver.sv - buffers a weight layer, replays it to the allocator, judges recovery, sweeps rows
module bisr_weight_alloc_driver
  import bisr_weight_alloc_driver_pkg::*;
#(
  parameter int SYSTOLIC_SIZE  = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  layer_start,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] src_weights,
  input  logic                                  src_valid,
  output logic                                  src_ready,
  output logic                                  allocation_start,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights,
  output logic                                  weight_valid,
  input  logic                                  recovery_done,
  input  logic                                  recovery_success,
  input  logic                                  compute_req,
  output logic [ADDR_WIDTH-1:0]                 read_addr,
  output logic                                  read_valid,
  output logic                                  layer_ready,
  output logic                                  layer_fail,
  output logic                                  fail_timeout,
  output logic [FAIL_COUNT_WIDTH-1:0]           fail_count
);

  localparam int ROW_WIDTH = SYSTOLIC_SIZE * WEIGHT_WIDTH;
  localparam int CNT_WIDTH = 16;

  state_e                      state, state_next;
  logic [CNT_WIDTH-1:0]        cnt, cnt_next;
  logic [ADDR_WIDTH-1:0]       wptr, wptr_next, buf_rd_addr, read_addr_next;
  logic                        wr_en;
  logic [ROW_WIDTH-1:0]        buf_rd_data, input_weights_next;
  logic                        weight_valid_next, read_valid_next;
  logic                        layer_ready_next, layer_fail_next, fail_timeout_next;
  logic [FAIL_COUNT_WIDTH-1:0] fail_count_next;

  bisr_row_buffer #(
    .DEPTH      (SYSTOLIC_SIZE),
    .ROW_WIDTH  (ROW_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (src_weights),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_next         = state;
    cnt_next           = cnt;
    wptr_next          = wptr;
    wr_en              = 1'b0;
    // Look one row ahead so input_weights can be registered
    buf_rd_addr        = (state == ST_START) ? '0 : ADDR_WIDTH'(cnt + 1'b1);
    weight_valid_next  = 1'b0;
    input_weights_next = '0;
    read_valid_next    = 1'b0;
    read_addr_next     = read_addr;
    layer_ready_next   = layer_ready;
    layer_fail_next    = layer_fail;
    fail_timeout_next  = fail_timeout;
    fail_count_next    = fail_count;

    case (state)
      ST_IDLE: begin
        if (layer_start) begin
          state_next = ST_FILL;
          wptr_next  = '0;
        end
      end
      ST_FILL: begin
        if (src_valid && src_ready) begin
          wr_en     = 1'b1;
          wptr_next = wptr + 1'b1;
          if (wptr == ADDR_WIDTH'(SYSTOLIC_SIZE - 1)) begin
            state_next = ST_START;
          end
        end
      end
      ST_START: begin
        state_next         = ST_STREAM;
        cnt_next           = '0;
        weight_valid_next  = 1'b1;
        input_weights_next = buf_rd_data;
      end
      ST_STREAM: begin
        if (cnt == CNT_WIDTH'(SYSTOLIC_SIZE - 1)) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next           = cnt + 1'b1;
          weight_valid_next  = 1'b1;
          input_weights_next = buf_rd_data;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
          state_next = ST_CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        // A done seen on the final budget cycle still wins over the timeout
        if (recovery_done) begin
          if (recovery_success) begin
            state_next       = ST_READY;
            layer_ready_next = 1'b1;
          end else begin
            state_next      = ST_FAIL;
            layer_fail_next = 1'b1;
            fail_count_next = sat_inc(fail_count);
          end
        end else if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_next        = ST_FAIL;
          layer_fail_next   = 1'b1;
          fail_timeout_next = 1'b1;
          fail_count_next   = sat_inc(fail_count);
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_READY, ST_FAIL: begin
        if (layer_start) begin
          state_next        = ST_FILL;
          wptr_next         = '0;
          layer_ready_next  = 1'b0;
          layer_fail_next   = 1'b0;
          fail_timeout_next = 1'b0;
        end else if (state == ST_READY && compute_req) begin
          state_next      = ST_SWEEP;
          read_valid_next = 1'b1;
          read_addr_next  = '0;
        end
      end
      ST_SWEEP: begin
        if (read_addr == ADDR_WIDTH'(SYSTOLIC_SIZE - 1)) begin
          state_next = ST_READY;
        end else begin
          read_valid_next = 1'b1;
          read_addr_next  = read_addr + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      wptr             <= '0;
      src_ready        <= 1'b0;
      allocation_start <= 1'b0;
      input_weights    <= '0;
      weight_valid     <= 1'b0;
      read_addr        <= '0;
      read_valid       <= 1'b0;
      layer_ready      <= 1'b0;
      layer_fail       <= 1'b0;
      fail_timeout     <= 1'b0;
      fail_count       <= '0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      wptr             <= wptr_next;
      src_ready        <= (state_next == ST_FILL);
      allocation_start <= (state_next == ST_START);
      input_weights    <= input_weights_next;
      weight_valid     <= weight_valid_next;
      read_addr        <= read_addr_next;
      read_valid       <= read_valid_next;
      layer_ready      <= layer_ready_next;
      layer_fail       <= layer_fail_next;
      fail_timeout     <= fail_timeout_next;
      fail_count       <= fail_count_next;
    end
  end

endmodule

// File: tb/tb_bisr_weight_alloc_driver.sv
// tb/tb_bisr_weight_alloc_driver.sv - self-checking bench for bisr_weight_alloc_driver
module tb_bisr_weight_alloc_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        layer_start;
  logic [63:0] src_weights;
  logic        src_valid;
  logic        src_ready;
  logic        allocation_start;
  logic [63:0] input_weights;
  logic        weight_valid;
  logic        recovery_done;
  logic        recovery_success;
  logic        compute_req;
  logic [2:0]  read_addr;
  logic        read_valid;
  logic        layer_ready;
  logic        layer_fail;
  logic        fail_timeout;
  logic [7:0]  fail_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bisr_weight_alloc_driver dut (
    .clk              (clk),
    .rst              (rst),
    .layer_start      (layer_start),
    .src_weights      (src_weights),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .allocation_start (allocation_start),
    .input_weights    (input_weights),
    .weight_valid     (weight_valid),
    .recovery_done    (recovery_done),
    .recovery_success (recovery_success),
    .compute_req      (compute_req),
    .read_addr        (read_addr),
    .read_valid       (read_valid),
    .layer_ready      (layer_ready),
    .layer_fail       (layer_fail),
    .fail_timeout     (fail_timeout),
    .fail_count       (fail_count)
  );

  typedef struct {
    logic [7:0] base;
    logic [7:0] gaps;
    logic       noise;
    int         done_at;
    logic       success;
    logic       exp_ready;
    logic       exp_fail;
    logic       exp_timeout;
    logic [7:0] exp_count;
  } layer_vec_t;

  layer_vec_t vecs [5];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [63:0] row_val(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic do_fill(input logic [7:0] base, input logic [7:0] gaps, input logic noise);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("fill_src_ready", src_ready, 1);
    chk("fill_flags_clear", {layer_ready, layer_fail, fail_timeout}, 0);
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        src_valid     = 1'b0;
        src_weights   = {$urandom, $urandom};
        recovery_done = noise;
        tick();
      end
      src_valid     = 1'b1;
      src_weights   = row_val(8'(base + i));
      recovery_done = noise & i[0];
      tick();
    end
    src_valid     = 1'b0;
    src_weights   = '0;
    chk("start_pulse", allocation_start, 1);
    chk("start_no_valid", weight_valid, 0);
    chk("start_src_ready", src_ready, 0);
  endtask

  task automatic do_stream(input logic [7:0] base, input logic noise, input int n);
    for (int i = 0; i < n; i++) begin
      recovery_done = noise & ~i[0];
      tick();
      chk("stream_valid", weight_valid, 1);
      chk("stream_row", input_weights, row_val(8'(base + i)));
      chk("stream_no_alloc", allocation_start, 0);
    end
    recovery_done = 1'b0;
  endtask

  task automatic do_outcome(input int done_at, input logic success, input logic e_ready,
                            input logic e_fail, input logic e_timeout, input logic [7:0] e_count);
    recovery_done = 1'b0;
    if (done_at < 0) begin
      repeat (18) tick();
      chk("timeout_not_early", layer_fail, 0);
      tick();
    end else begin
      repeat (3 + done_at) tick();
      chk("check_waiting", {layer_ready, layer_fail}, 0);
      recovery_done    = 1'b1;
      recovery_success = success;
      tick();
      recovery_done    = 1'b0;
      recovery_success = 1'b0;
    end
    chk("outcome_ready", layer_ready, e_ready);
    chk("outcome_fail", layer_fail, e_fail);
    chk("outcome_timeout", fail_timeout, e_timeout);
    chk("outcome_count", fail_count, e_count);
  endtask

  initial begin
    //           base   gaps        noise done  succ rdy  fail tmo  count
    vecs[0] = '{8'h01, 8'b00000000, 1'b0, 0,    1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{8'h10, 8'b10100110, 1'b1, 3,    1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{8'h20, 8'b00000000, 1'b0, 0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[3] = '{8'h30, 8'b01000001, 1'b0, -1,   1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[4] = '{8'h40, 8'b00000000, 1'b0, 15,   1'b1, 1'b1, 1'b0, 1'b0, 8'd2};

    rst              = 1'b1;
    layer_start      = 1'b0;
    src_weights      = '0;
    src_valid        = 1'b0;
    recovery_done    = 1'b0;
    recovery_success = 1'b0;
    compute_req      = 1'b0;
    repeat (2) tick();
    chk("reset_src_ready", src_ready, 0);
    chk("reset_alloc", allocation_start, 0);
    chk("reset_wvalid", weight_valid, 0);
    chk("reset_weights", input_weights, 0);
    chk("reset_read", {read_valid, read_addr}, 0);
    chk("reset_flags", {layer_ready, layer_fail, fail_timeout}, 0);
    chk("reset_count", fail_count, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      do_fill(vecs[v].base, vecs[v].gaps, vecs[v].noise);
      do_stream(vecs[v].base, vecs[v].noise, 8);
      do_outcome(vecs[v].done_at, vecs[v].success, vecs[v].exp_ready,
                 vecs[v].exp_fail, vecs[v].exp_timeout, vecs[v].exp_count);
    end

    // Row sweep; a second compute_req mid-sweep must be dropped
    compute_req = 1'b1;
    tick();
    compute_req = 1'b0;
    for (int a = 0; a < 8; a++) begin
      chk("sweep_valid", read_valid, 1);
      chk("sweep_addr", read_addr, 64'(a));
      compute_req = (a == 3);
      tick();
    end
    compute_req = 1'b0;
    chk("sweep_end_valid", read_valid, 0);
    chk("sweep_addr_hold", read_addr, 7);
    chk("sweep_still_ready", layer_ready, 1);
    repeat (2) tick();
    chk("sweep_not_queued", read_valid, 0);

    // layer_start ignored mid-stream, then async reset at row 4
    do_fill(8'h60, 8'b00000000, 1'b0);
    do_stream(8'h60, 1'b0, 4);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("stream_ignores_start", weight_valid, 1);
    chk("stream_row4", input_weights, row_val(8'h64));
    rst = 1'b1;
    #1;
    chk("async_rst_wvalid", weight_valid, 0);
    chk("async_rst_weights", input_weights, 0);
    chk("async_rst_flags", {layer_ready, layer_fail, fail_timeout, allocation_start, src_ready}, 0);
    chk("async_rst_count", fail_count, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_rst", src_ready, 0);

    do_fill(8'h70, 8'b00010000, 1'b0);
    do_stream(8'h70, 1'b0, 8);
    do_outcome(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
